// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the fetch/data RAM port arbiter:
//   - default address/data widths
//   - read-owner encoding (who gets ram_rdata next cycle)
//   - arbiter FSM state encoding
//   - width helper for the streak counter
package mem_port_arbiter_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } own_e;

    typedef enum logic {
        ARB_DPRI   = 1'b0,
        ARB_FFORCE = 1'b1
    } arb_state_e;

    // Counter width that can hold max_streak, never narrower than 2 bits.
    function automatic int streak_width(input int max_streak);
        int w;
        w = $clog2(max_streak + 1);
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch requester, data requester and RAM port signals.
//   slave  : arbiter view (requests/ram_rdata in; grants, stalls, read data, RAM controls out)
//   master : pipeline + RAM view (the mirror image)
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    // fetch path
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_stall;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    // data path
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    // RAM port
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
        output if_gnt, if_stall, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output ram_addr, ram_wdata, ram_we
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
        input  if_gnt, if_stall, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  ram_addr, ram_wdata, ram_we
    );

endinterface

// File: rtl/mem_port_arbiter_streak_ctr.sv
// arb_streak_ctr
// Saturating count of consecutive contended data grants.
//   clk    : clock
//   reset  : synchronous active-high reset, clears the count
//   inc_i  : a contended data grant happened this cycle
//   clr_i  : clear the count (takes precedence over inc_i)
//   hit_o  : the next increment brings the count to MAX_STREAK, so the
//            arbiter can switch to fetch priority on the very grant that
//            completes the streak
module arb_streak_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic hit_o
);
    localparam int            CW    = streak_width(MAX_STREAK);
    localparam logic [CW-1:0] MAX_V = CW'(MAX_STREAK);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == (MAX_V - 1'b1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM between the IF fetch path and the MEM data path.
// One grant per cycle, combinational from the requests; read data comes back
// one cycle later to whichever side owned the read. Data wins contention,
// except that after MAX_DATA_STREAK consecutive contended data wins the next
// contended cycle is forced to fetch.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave modport of mem_port_arbiter_if (fetch, data, RAM port)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);
    arb_state_e state_q;
    arb_state_e state_d;
    own_e       rd_own_q;
    own_e       rd_own_d;

    logic if_gnt;
    logic dm_gnt;
    logic streak_inc;
    logic streak_clr;
    logic streak_hit;

    arb_streak_ctr #(
        .MAX_STREAK (MAX_DATA_STREAK)
    ) u_streak (
        .clk   (clk),
        .reset (reset),
        .inc_i (streak_inc),
        .clr_i (streak_clr),
        .hit_o (streak_hit)
    );

    // Grant decision and next state. Everything is held off while reset is
    // high so the RAM never sees a write during reset.
    always_comb begin
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        streak_inc = 1'b0;
        streak_clr = 1'b0;
        state_d    = ARB_DPRI;
        rd_own_d   = OWN_NONE;

        if (!reset) begin
            if ((state_q == ARB_FFORCE) && bus.if_req) begin
                if_gnt     = 1'b1;
                streak_clr = 1'b1;
            end else begin
                // Data-priority arbitration; also the fallback for a forced
                // cycle in which fetch is not asking.
                if (bus.dm_req) begin
                    dm_gnt = 1'b1;
                    if (bus.if_req) begin
                        streak_inc = 1'b1;
                        if (streak_hit) begin
                            state_d    = ARB_FFORCE;
                            streak_clr = 1'b1;
                        end
                    end else begin
                        streak_clr = 1'b1;
                    end
                end else begin
                    // Fetch-only or idle: any fetch grant breaks the streak.
                    if_gnt     = bus.if_req;
                    streak_clr = 1'b1;
                end
            end

            if (dm_gnt && !bus.dm_we) begin
                rd_own_d = OWN_DM;
            end else if (if_gnt) begin
                rd_own_d = OWN_IF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_DPRI;
            rd_own_q <= OWN_NONE;
        end else begin
            state_q  <= state_d;
            rd_own_q <= rd_own_d;
        end
    end

    // RAM port mux and requester-facing outputs. rvalid is also masked by
    // reset so a read granted just before reset never reports completion.
    always_comb begin
        bus.if_gnt    = if_gnt;
        bus.dm_gnt    = dm_gnt;
        bus.if_stall  = bus.if_req & ~if_gnt;
        bus.ram_addr  = dm_gnt ? bus.dm_addr  : bus.if_addr;
        bus.ram_wdata = dm_gnt ? bus.dm_wdata : '0;
        bus.ram_we    = dm_gnt & bus.dm_we;
        bus.if_rvalid = ~reset & (rd_own_q == OWN_IF);
        bus.dm_rvalid = ~reset & (rd_own_q == OWN_DM);
        bus.if_rdata  = bus.ram_rdata;
        bus.dm_rdata  = bus.ram_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed stimulus with hand-computed expectations. Each step drives one
// cycle of requests and checks grants/stall/RAM controls; expected read
// responses are queued and a separate monitor checks rvalid/rdata each cycle.
module tb_mem_port_arbiter;
    localparam int G_N = 0;
    localparam int G_I = 1;
    localparam int G_D = 2;

    typedef struct {
        int          cyc;
        bit          own_if;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    bit   mon_en;
    exp_t exp_q[$];

    mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_port_arbiter #(
        .MAX_DATA_STREAK (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered read, write at the edge. Unwritten words return
    // a fixed preload pattern.
    logic [15:0] wr_data [256];
    bit          wr_seen [256];

    function automatic logic [15:0] init_word(input logic [15:0] a);
        case (a)
            16'h0001: return 16'hA001;
            16'h0002: return 16'hB002;
            16'h0010: return 16'h1234;
            16'h0020: return 16'h2020;
            16'h0030: return 16'h3030;
            default:  return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.ram_we) begin
            wr_data[bus.ram_addr[7:0]] <= bus.ram_wdata;
            wr_seen[bus.ram_addr[7:0]] <= 1'b1;
        end
        bus.ram_rdata <= wr_seen[bus.ram_addr[7:0]] ? wr_data[bus.ram_addr[7:0]]
                                                    : init_word(bus.ram_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One cycle of stimulus. g is the expected grant; rd is the expected read
    // data for a granted read; push=0 suppresses the response expectation.
    task automatic step(input logic rs, input logic ir, input logic [15:0] ia,
                        input logic dr, input logic dw, input logic [15:0] da,
                        input logic [15:0] dwd, input int g, input bit push,
                        input logic [15:0] rd);
        exp_t e;
        @(negedge clk);
        #1;
        reset        = rs;
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.dm_req   = dr;
        bus.dm_we    = dw;
        bus.dm_addr  = da;
        bus.dm_wdata = dwd;
        #1;
        chk("if_gnt",   32'(bus.if_gnt),   32'(g == G_I));
        chk("dm_gnt",   32'(bus.dm_gnt),   32'(g == G_D));
        chk("if_stall", 32'(bus.if_stall), 32'(ir && (g != G_I)));
        chk("ram_we",   32'(bus.ram_we),   32'((g == G_D) && dw));
        if (g == G_I) chk("ram_addr_if", 32'(bus.ram_addr), 32'(ia));
        if (g == G_D) chk("ram_addr_dm", 32'(bus.ram_addr), 32'(da));
        if ((g == G_D) && dw) chk("ram_wdata", 32'(bus.ram_wdata), 32'(dwd));
        if (push && (g != G_N) && !((g == G_D) && dw)) begin
            e.cyc    = cyc + 1;
            e.own_if = (g == G_I);
            e.data   = rd;
            exp_q.push_back(e);
        end
        $display("step cyc=%0d rst=%0b if_req=%0b dm_req=%0b we=%0b -> if_gnt=%0b dm_gnt=%0b",
                 cyc, rs, ir, dr, dw, bus.if_gnt, bus.dm_gnt);
    endtask

    // Response monitor: every cycle either a queued response is due, or
    // neither rvalid may be high.
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            #3;
            if ((exp_q.size() > 0) && (exp_q[0].cyc == cyc)) begin
                e = exp_q.pop_front();
                chk("if_rvalid", 32'(bus.if_rvalid), 32'(e.own_if));
                chk("dm_rvalid", 32'(bus.dm_rvalid), 32'(!e.own_if));
                chk(e.own_if ? "if_rdata" : "dm_rdata",
                    32'(e.own_if ? bus.if_rdata : bus.dm_rdata), 32'(e.data));
            end else begin
                chk("if_rvalid_idle", 32'(bus.if_rvalid), 32'd0);
                chk("dm_rvalid_idle", 32'(bus.dm_rvalid), 32'd0);
            end
        end
    end

    initial begin
        cyc          = 0;
        n_cmp        = 0;
        n_bad        = 0;
        mon_en       = 1'b0;
        reset        = 1'b1;
        bus.if_req   = 1'b0;
        bus.if_addr  = 16'h0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 16'h0;
        bus.dm_wdata = 16'h0;

        // Reset held with both requests pending: no grants.
        step(1, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_N, 1, 16'h0);
        mon_en = 1'b1;
        step(1, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_N, 1, 16'h0);
        // Release with both pending: data first.
        step(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_D, 1, 16'h3030);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0, G_N, 1, 16'h0);

        // Fetch only.
        step(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0, G_I, 1, 16'h1234);
        // Data write, then read back.
        step(0, 0, 16'h0000, 1, 1, 16'h00F0, 16'hBEEF, G_D, 1, 16'h0);
        step(0, 0, 16'h0000, 1, 0, 16'h00F0, 16'h0, G_D, 1, 16'hBEEF);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0, G_N, 1, 16'h0);

        // Contention for 8 cycles: D,D,D,F,D,D,D,F.
        for (int i = 0; i < 8; i++) begin
            if ((i % 4) == 3)
                step(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_I, 1, 16'h2020);
            else
                step(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_D, 1, 16'h3030);
        end

        // Streak broken by one cycle without a fetch request.
        step(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_D, 1, 16'h3030);
        step(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_D, 1, 16'h3030);
        step(0, 0, 16'h0020, 1, 0, 16'h0030, 16'h0, G_D, 1, 16'h3030);
        step(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_D, 1, 16'h3030);
        step(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_D, 1, 16'h3030);
        step(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_D, 1, 16'h3030);
        step(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_I, 1, 16'h2020);

        // Back-to-back alternating reads, no bubbles.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 16'h0001, 0, 0, 16'h0000, 16'h0, G_I, 1, 16'hA001);
            step(0, 0, 16'h0000, 1, 0, 16'h0002, 16'h0, G_D, 1, 16'hB002);
        end

        // Reset right after a granted data read: its rvalid must be dropped.
        step(0, 0, 16'h0000, 1, 0, 16'h0030, 16'h0, G_D, 0, 16'h0);
        step(1, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_N, 1, 16'h0);
        step(1, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_N, 1, 16'h0);
        step(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_D, 1, 16'h3030);
        step(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_D, 1, 16'h3030);
        step(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_D, 1, 16'h3030);
        step(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0, G_I, 1, 16'h2020);

        // Drain.
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0, G_N, 1, 16'h0);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0, G_N, 1, 16'h0);
        @(negedge clk);
        #4;
        chk("resp_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
